mux_arb_nto1: RTL
=================

Name: mux_arb_nto1

Overview:
- N-channel, WIDTH-bit arbitrated multiplexer with a valid/ready handshake on every input and on the output.
- It generalises the plain 2:1 16-bit select to N sources with internal arbitration: round-robin or fixed priority.
- The output is registered, so one beat is buffered and there is a 1-cycle input-to-output latency.
- It is used wherever several datapath producers share one consumer, for example register-file write-back sources or a shared bus.

Parameters:
- WIDTH, 16, data width per channel in bits (>=1).
- N, 4, number of input channels (>=2).
- RR, 1, arbitration mode: 1 = round-robin, 0 = fixed priority (lowest index wins).
- SELW is a localparam equal to clog2(N). It is not user-set.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  in  N  per-channel valid.
- in_ready  out  N  per-channel ready; one-hot or all zero.
- out_data  out  WIDTH  registered selected data.
- out_valid  out  1  output register holds a beat.
- out_ready  in  1  consumer accepts the beat.
- out_sel  out  SELW  index of the channel that supplied out_data.

Behaviour:
- Reset (rst=1 at the rising edge): out_valid=0, out_data=0, out_sel=0, round-robin pointer ptr=0. While rst=1, in_ready=0 combinationally.
- Define accept_en = !out_valid | out_ready.
- Grant logic is combinational from in_valid and ptr.
  - RR=1: winner is the first i with in_valid[i]=1, scanning ptr, ptr+1, ... N-1, 0, ... ptr-1 (mod N).
  - RR=0: winner is the lowest i with in_valid[i]=1; ptr is unused and held at 0.
- in_ready[winner] = accept_en & !rst. All other in_ready bits are 0. If no channel is valid, in_ready = 0.
- A transfer from channel i happens when in_valid[i] & in_ready[i] at a rising edge. On that edge:
  - out_data <= channel i data.
  - out_sel <= i.
  - out_valid <= 1.
  - If RR=1, ptr <= (i+1) mod N. When i=N-1, ptr wraps to 0.
- Output drain: if out_valid & out_ready and there is no new transfer, out_valid <= 0. out_data and out_sel hold their last values.
- Simultaneous drain and fill: the new beat replaces the old one in the same cycle and out_valid stays 1. This gives full throughput of 1 beat per cycle with no bubble.
- Stall (out_valid & !out_ready): out_data and out_sel are held stable, all in_ready=0, and ptr is unchanged.
- ptr advances only on an accepted transfer. It never advances on idle cycles or on stalled cycles.
- Latency: a beat accepted at edge k is visible on out_* after edge k and can be consumed at edge k+1 or later.
- No combinational path from out_ready to out_valid or out_data. The path from out_ready to in_ready is permitted.
- in_valid is assumed to follow the protocol: once raised, it is held with stable data until accepted. The block does not check this.
- Reset mid-operation: a buffered beat is discarded (out_valid=0), ptr returns to 0, and no transfer occurs on the reset edge.
- For N that is not a power of 2, ptr and out_sel never hold values >= N.

Test Plan:
- Reset: drive rst=1 for 2 cycles with all in_valid=1 -> in_ready=0000, out_valid=0, out_data=0, out_sel=0. After release, channel 0 is granted first.
- Single channel, full throughput: in_valid=0100, data 0x1234, out_ready=1 held -> out_valid=1 and out_sel=2 from the next cycle, in_ready=0100 every cycle, 1 beat per cycle.
- Round-robin fairness (RR=1, N=4): all in_valid=1, out_ready=1, channel i data = 0xA000+i -> out_sel sequence 0,1,2,3,0,1 with matching data; ptr wraps after 3.
- Fixed priority (RR=0): in_valid=1010 continuously -> out_sel=1 on every beat and channel 3 is never granted. Dropping in_valid[1] -> out_sel=3 on the next beat.
- Backpressure: out_valid=1 carrying 0x00FF and out_ready=0 for 3 cycles with in_valid=1111 -> in_ready=0000, out_data stays 0x00FF, ptr is frozen. When out_ready rises, the next grant comes from the held ptr.
- Mid-stream reset and odd N (N=3, WIDTH=8): assert rst while out_valid=1 -> out_valid=0 on the next edge. With all channels valid after release, out_sel cycles 0,1,2,0 and never reaches 3.

Source files
------------

// File: rtl/mux_arb_nto1.sv
// N-channel arbitrated multiplexer with valid/ready on every input and on the
// registered output. Round-robin (RR=1) or fixed lowest-index priority (RR=0).
// One beat is buffered in the output register, giving 1-cycle latency and
// full throughput when the consumer drains while a new beat fills.
module mux_arb_nto1 #(
  parameter int WIDTH = 16,
  parameter int N     = 4,
  parameter int RR    = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N*WIDTH-1:0]     in_data,
  input  logic [N-1:0]           in_valid,
  output logic [N-1:0]           in_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(N)-1:0]   out_sel
);

  localparam int SELW = $clog2(N);
  localparam logic [SELW:0] NUM = (SELW+1)'(N);
  localparam logic [SELW:0] ONE = (SELW+1)'(1);

  logic [SELW-1:0]  ptr_q, ptr_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SELW-1:0]  out_sel_q, out_sel_d;

  logic [SELW-1:0]  win;
  logic             found;
  logic             accept_en;
  logic             grant;
  logic [WIDTH-1:0] sel_data;

  // (base + off) mod N; keeps indices below N even when N is not a power of 2
  function automatic logic [SELW-1:0] mod_add(input logic [SELW-1:0] base,
                                              input logic [SELW:0]   off);
    logic [SELW:0] s;
    s = {1'b0, base} + off;
    if (s >= NUM) s = s - NUM;
    return s[SELW-1:0];
  endfunction

  // Scan channels starting at ptr (ptr stays 0 in fixed-priority mode)
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < N; k++) begin
      if (!found && in_valid[mod_add(ptr_q, (SELW+1)'(k))]) begin
        found = 1'b1;
        win   = mod_add(ptr_q, (SELW+1)'(k));
      end
    end
  end

  // Select the winning channel's data
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (win == SELW'(i)) sel_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  assign accept_en = !out_valid_q | out_ready;
  assign grant     = found & accept_en & !rst;

  // One-hot ready to the winner only, and only when the output can take a beat
  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N; i++) begin
      in_ready[i] = grant && (win == SELW'(i));
    end
  end

  // Next-state: fill on grant (replacing any beat being drained), else drain
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
    if (grant) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_data;
      out_sel_d   = win;
      if (RR != 0) ptr_d = mod_add(win, ONE);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output register and round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule
